// File: rtl/column_scan_controller_pkg.sv
// Shared types and defaults for the LED matrix column scan controller.
package column_scan_controller_pkg;

  localparam int unsigned NumColumnsDefault  = 16;
  localparam int unsigned DwellCyclesDefault = 1024;

  typedef enum logic [3:0] {
    StIdle,
    StReq,
    StTxStart,
    StTxWait,
    StBlank,
    StSelect,
    StSelWait,
    StLatch,
    StDwell
  } scan_state_t;

endpackage

// File: rtl/column_scan_controller_if.sv
// Handshake bundle between the scan controller (master) and its frame buffer,
// row shifter and column selector neighbours (slave side).
interface column_scan_controller_if #(
  parameter int unsigned COL_W = 4
);

  logic             enable;
  logic [COL_W-1:0] col_index;
  logic             col_data_req;
  logic             col_data_ack;
  logic             row_tx_start;
  logic             row_tx_finish;
  logic             row_stcp;
  logic             row_n_oe;
  logic             sel_first;
  logic             sel_next;
  logic             sel_ready;
  logic             extra_bit;
  logic             frame_done;

  modport master (
    input  enable, col_data_ack, row_tx_finish, sel_ready,
    output col_index, col_data_req, row_tx_start, row_stcp, row_n_oe,
    output sel_first, sel_next, extra_bit, frame_done
  );

  modport slave (
    output enable, col_data_ack, row_tx_finish, sel_ready,
    input  col_index, col_data_req, row_tx_start, row_stcp, row_n_oe,
    input  sel_first, sel_next, extra_bit, frame_done
  );

endinterface

// File: rtl/column_scan_controller_dwell_timer.sv
// Dwell timer: a start pulse arms it, then it counts 0..DWELL_CYCLES-1 and
// flags the final counted cycle with done.
module column_scan_controller_dwell_timer #(
  parameter int unsigned DWELL_CYCLES = 1024,
  localparam int unsigned CNT_W = $clog2(DWELL_CYCLES + 1)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  output logic done
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             run_q, run_d;

  // Next count and the last-cycle flag.
  always_comb begin
    done  = run_q && (cnt_q == CNT_W'(DWELL_CYCLES - 1));
    cnt_d = cnt_q;
    run_d = run_q;
    if (start) begin
      cnt_d = '0;
      run_d = 1'b1;
    end else if (done) begin
      cnt_d = '0;
      run_d = 1'b0;
    end else if (run_q) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Counter state with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
      run_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      run_q <= run_d;
    end
  end

endmodule

// File: rtl/column_scan_controller.sv
// Per-column scan sequencer: fetch rows, shift them out, blank, step the
// column selector, latch and hold the column lit for a fixed dwell.
module column_scan_controller
  import column_scan_controller_pkg::*;
#(
  parameter int unsigned NUM_COLUMNS  = NumColumnsDefault,
  parameter int unsigned DWELL_CYCLES = DwellCyclesDefault,
  parameter int unsigned COL_W        = (NUM_COLUMNS > 1) ? $clog2(NUM_COLUMNS) : 1
) (
  input logic clk,
  input logic rst_n,
  column_scan_controller_if.master bus
);

  scan_state_t      state_q, state_d;
  logic [COL_W-1:0] col_q, col_d;
  logic             parity_q, parity_d;
  logic             req_q, req_d;
  logic             tx_start_q, tx_start_d;
  logic             stcp_q, stcp_d;
  logic             oe_n_q, oe_n_d;
  logic             sel_first_q, sel_first_d;
  logic             sel_next_q, sel_next_d;
  logic             frame_done_q, frame_done_d;
  logic             frame_end;
  logic             dwell_done;
  logic             last_col;
  logic             sel_active;
  logic             sel_hold;

  assign last_col   = (col_q == COL_W'(NUM_COLUMNS - 1));
  assign sel_active = sel_first_q | sel_next_q;

  column_scan_controller_dwell_timer #(
    .DWELL_CYCLES (DWELL_CYCLES)
  ) u_dwell_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .start (state_q == StLatch),
    .done  (dwell_done)
  );

  // State, column, parity and output registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      col_q        <= '0;
      parity_q     <= 1'b0;
      req_q        <= 1'b0;
      tx_start_q   <= 1'b0;
      stcp_q       <= 1'b0;
      oe_n_q       <= 1'b1;
      sel_first_q  <= 1'b0;
      sel_next_q   <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      col_q        <= col_d;
      parity_q     <= parity_d;
      req_q        <= req_d;
      tx_start_q   <= tx_start_d;
      stcp_q       <= stcp_d;
      oe_n_q       <= oe_n_d;
      sel_first_q  <= sel_first_d;
      sel_next_q   <= sel_next_d;
      frame_done_q <= frame_done_d;
    end
  end

  // Next-state, column advance and frame parity.
  always_comb begin
    state_d   = state_q;
    col_d     = col_q;
    parity_d  = parity_q;
    frame_end = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (bus.enable) begin
          col_d    = '0;
          parity_d = ~parity_q;
          state_d  = StReq;
        end
      end
      StReq:     if (bus.col_data_ack) state_d = StTxStart;
      // Only a sampled low proves the shifter took the start.
      StTxStart: if (!bus.row_tx_finish) state_d = StTxWait;
      StTxWait:  if (bus.row_tx_finish) state_d = StBlank;
      StBlank:   state_d = StSelect;
      StSelect:  if (sel_active && !bus.sel_ready) state_d = StSelWait;
      StSelWait: if (bus.sel_ready) state_d = StLatch;
      StLatch:   state_d = StDwell;
      StDwell: begin
        if (dwell_done) begin
          if (!last_col) begin
            col_d   = col_q + COL_W'(1);
            state_d = StReq;
          end else begin
            frame_end = 1'b1;
            col_d     = '0;
            if (bus.enable) begin
              parity_d = ~parity_q;
              state_d  = StReq;
            end else begin
              state_d = StIdle;
            end
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Registered outputs follow the state being entered.
  always_comb begin
    req_d        = (state_d == StReq);
    tx_start_d   = (state_d == StTxStart);
    stcp_d       = (state_d == StLatch);
    oe_n_d       = (state_d != StDwell);
    frame_done_d = frame_end;
    // Raise the select only after seeing ready inside SELECT, then hold it.
    sel_hold     = (state_q == StSelect) && (state_d == StSelect) &&
                   (sel_active || bus.sel_ready);
    sel_first_d  = sel_hold && (col_q == '0);
    sel_next_d   = sel_hold && (col_q != '0);
  end

  assign bus.col_index    = col_q;
  assign bus.col_data_req = req_q;
  assign bus.row_tx_start = tx_start_q;
  assign bus.row_stcp     = stcp_q;
  assign bus.row_n_oe     = oe_n_q;
  assign bus.sel_first    = sel_first_q;
  assign bus.sel_next     = sel_next_q;
  assign bus.extra_bit    = parity_q;
  assign bus.frame_done   = frame_done_q;

endmodule

// File: doc/column_scan_controller.md
Name: column_scan_controller

Overview:
- Per-column scan sequencer for the LED matrix output stage; sits directly upstream of the column selector.
- For each column it fetches the row data for the current column from the frame buffer side and shifts it out through the row shifter.
- It then blanks the matrix, commands the column selector (select first / select next), latches the rows and holds the column lit for a fixed dwell time.
- Runs frame after frame while enabled.

Parameters:
- NUM_COLUMNS, 16, columns per frame (>=1).
- DWELL_CYCLES, 1024, clk cycles each column is lit (>=1).
- COL_W, $clog2(NUM_COLUMNS) (min 1), width of col_index.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset; one clock; synchronous and active-low.
- enable  in  1  run scanning; sampled only in IDLE and at frame end.
- col_index  out  COL_W  column currently being loaded/displayed.
- col_data_req  out  1  request row data for col_index.
- col_data_ack  in  1  row data for col_index is present on the row shifter input.
- row_tx_start  out  1  start the row shifter; held until row_tx_finish goes low.
- row_tx_finish  in  1  row shifter idle/done (high when idle).
- row_stcp  out  1  one-cycle row storage latch pulse.
- row_n_oe  out  1  row output enable, active low.
- sel_first  out  1  to column selector select_first.
- sel_next  out  1  to column selector select_next.
- sel_ready  in  1  column selector ready.
- extra_bit  out  1  frame parity, toggles at every frame start.
- frame_done  out  1  one-cycle pulse after the last column's dwell.

Behaviour:
- All outputs registered.
- Reset values: col_index=0, row_n_oe=1, all other outputs 0, state IDLE, parity 0, dwell counter 0.
- Reset mid-operation: same values on the next edge. Any in-flight shifter or selector transfer is abandoned.
- FSM states and transitions:
  - IDLE: if enable, set col_index=0, toggle extra_bit, go to REQ.
  - REQ: col_data_req=1 until col_data_ack is sampled high (ack in the first REQ cycle is accepted). Clear req on the following edge, go to TX_START.
  - TX_START: row_tx_start=1 until row_tx_finish is sampled low, then deassert and go to TX_WAIT. Never finish an assertion against a finish that is already high-and-idle without seeing the low.
  - TX_WAIT: wait row_tx_finish=1, then go to BLANK.
  - BLANK: row_n_oe=1 (already 1 unless coming from DWELL). One cycle, then go to SELECT.
  - SELECT:
    - Wait sel_ready=1.
    - Then assert sel_first if col_index==0, else sel_next. Never both.
    - Hold it until sel_ready is sampled low, then deassert and go to SEL_WAIT.
    - After reset the selector is not ready for its startup shift; the controller simply waits.
  - SEL_WAIT: wait sel_ready=1 (column shifted and latched), then go to LATCH.
  - LATCH: row_stcp=1 for exactly one cycle, then go to DWELL.
  - DWELL:
    - row_n_oe=0 for exactly DWELL_CYCLES cycles. Counter runs 0..DWELL_CYCLES-1.
    - On the last cycle, if col_index<NUM_COLUMNS-1: increment col_index, go to REQ.
    - Otherwise pulse frame_done. If enable, wrap col_index to 0, toggle extra_bit, go to REQ; else col_index=0, go to IDLE.
    - row_n_oe returns to 1 on the edge leaving DWELL.
- row_n_oe=1 in every state except DWELL, so the matrix is blanked during shifting and column change.
- enable deasserted mid-frame: the frame completes, then IDLE.
- NUM_COLUMNS=1: every column uses sel_first; col_index stays 0.
- col_data_ack or sel_ready glitches outside their states are ignored.
- Counter widths must not overflow: size the dwell counter to $clog2(DWELL_CYCLES+1).

Decomposition:
- Shared output-module package: scan_state_t enum (IDLE, REQ, TX_START, TX_WAIT, BLANK, SELECT, SEL_WAIT, LATCH, DWELL) and default NUM_COLUMNS / DWELL_CYCLES constants.
- One sub-module is natural: dwell_timer (load/start, done pulse after N cycles).
- Shifter and column selector are instantiated by the parent, not here.

Test Plan:
- Reset: rst_n low for 3 cycles mid-DWELL -> next edge row_n_oe=1, sel_first=sel_next=row_stcp=0, col_index=0, FSM IDLE.
- NUM_COLUMNS=4, DWELL_CYCLES=8, enable=1, ack 2 cycles after req, shifter finish low 1 cycle after start for 10 cycles, selector ready drops 1 cycle after select -> sequence sel_first, sel_next x3. col_index 0,1,2,3,0. row_n_oe low exactly 8 cycles per column. frame_done single pulse after column 3. extra_bit toggles each frame.
- Selector sel_ready held low 50 cycles after reset -> sel_first stays 0 until sel_ready rises, then held until sel_ready low. No row_stcp before SEL_WAIT completes.
- enable dropped during column 1 of a 4-column frame -> columns 2,3 still displayed, one frame_done, then IDLE with row_n_oe=1.
- Ack asserted same cycle as col_data_req rises -> accepted, req high exactly 1 cycle.
- NUM_COLUMNS=1, DWELL_CYCLES=1 -> sel_first every frame, never sel_next. row_n_oe low 1 cycle per frame. frame_done every frame.
